// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel-clock divider, sync decode,
// line/frame/prefetch strobes and a wrapping completed-frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int CX            = 10,
  parameter int CY            = 10,
  parameter int SYNC_POL      = 0,
  parameter int PIX_DIV       = 2,
  parameter int PREFETCH_LINE = 524,
  parameter int FRAME_BITS    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  pix_en,
  output logic [CX-1:0]         x,
  output logic [CY-1:0]         y,
  output logic                  active,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  prefetch_req,
  output logic [FRAME_BITS-1:0] frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [CX-1:0] X_LAST = CX'(H_TOTAL - 1);
  localparam logic [CX-1:0] X_ACT = CX'(H_ACTIVE);
  localparam logic [CX-1:0] HS_BEG = CX'(H_ACTIVE + H_FP);
  localparam logic [CX-1:0] HS_END = CX'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CY-1:0] Y_LAST = CY'(V_TOTAL - 1);
  localparam logic [CY-1:0] Y_ACT = CY'(V_ACTIVE);
  localparam logic [CY-1:0] VS_BEG = CY'(V_ACTIVE + V_FP);
  localparam logic [CY-1:0] VS_END = CY'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CY-1:0] Y_PF = CY'(PREFETCH_LINE);
  localparam logic POL = 1'(SYNC_POL);
  logic [DW-1:0] div;
  logic          tick;
  logic [CX-1:0] nx;
  logic [CY-1:0] ny;
  // Outputs are decoded from the position the tick is about to enter.
  always_comb begin
    tick = en && div == DIV_LAST;
    nx = x == X_LAST ? '0 : x + 1'b1;
    ny = x != X_LAST ? y : y == Y_LAST ? '0 : y + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div          <= '0;
      x            <= X_LAST;
      y            <= Y_LAST;
      frame_cnt    <= '0;
      pix_en       <= 1'b0;
      active       <= 1'b0;
      hsync        <= ~POL;
      vsync        <= ~POL;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      prefetch_req <= 1'b0;
    end else if (!en) begin
      div          <= '0;
      x            <= X_LAST;
      y            <= Y_LAST;
      pix_en       <= 1'b0;
      active       <= 1'b0;
      hsync        <= ~POL;
      vsync        <= ~POL;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      prefetch_req <= 1'b0;
    end else begin
      div          <= tick ? '0 : div + 1'b1;
      pix_en       <= tick;
      line_start   <= tick && nx == '0;
      frame_start  <= tick && nx == '0 && ny == '0;
      prefetch_req <= tick && nx == '0 && ny == Y_PF;
      if (tick) begin
        x      <= nx;
        y      <= ny;
        active <= nx < X_ACT && ny < Y_ACT;
        hsync  <= (nx >= HS_BEG && nx < HS_END) ? POL : ~POL;
        vsync  <= (ny >= VS_BEG && ny < VS_END) ? POL : ~POL;
        if (nx == '0 && ny == '0) frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three configurations checked every clock against a position-from-tick-count
// model, plus a vector table and hand sequences for enable, sync and async-reset corners.
module tb_vga_timing_gen;
  typedef struct packed {
    logic        pe;
    logic [15:0] x;
    logic [15:0] y;
    logic        act, hs, vs, ls, fs, pf;
    logic [7:0]  fc;
  } obs_t;
  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, pol, dv, pf, fb;
  } cfg_t;
  typedef struct {
    bit   en;
    obs_t e;
  } vec_t;

  cfg_t cfg[3] = '{
    '{640, 16, 96, 48, 480, 10, 2, 33, 0, 2, 524, 8},
    '{16, 4, 6, 6, 12, 2, 2, 3, 0, 2, 17, 2},
    '{8, 2, 2, 2, 4, 1, 1, 1, 1, 1, 0, 3}
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] en = 3'b000;
  int tests = 0;
  int fails = 0;
  obs_t ob[3];

  logic pe0, act0, hs0, vs0, ls0, fs0, pf0;
  logic [9:0] x0, y0;
  logic [7:0] fc0;
  logic pe1, act1, hs1, vs1, ls1, fs1, pf1;
  logic [4:0] x1, y1;
  logic [1:0] fc1;
  logic pe2, act2, hs2, vs2, ls2, fs2, pf2;
  logic [3:0] x2;
  logic [2:0] y2;
  logic [2:0] fc2;

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .pix_en(pe0), .x(x0), .y(y0), .active(act0),
    .hsync(hs0), .vsync(vs0), .line_start(ls0), .frame_start(fs0), .prefetch_req(pf0),
    .frame_cnt(fc0)
  );
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(12), .V_FP(2), .V_SYNC(2),
    .V_BP(3), .CX(5), .CY(5), .SYNC_POL(0), .PIX_DIV(2), .PREFETCH_LINE(17), .FRAME_BITS(2)
  ) u_mid (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .pix_en(pe1), .x(x1), .y(y1), .active(act1),
    .hsync(hs1), .vsync(vs1), .line_start(ls1), .frame_start(fs1), .prefetch_req(pf1),
    .frame_cnt(fc1)
  );
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .CX(4), .CY(3), .SYNC_POL(1), .PIX_DIV(1), .PREFETCH_LINE(0), .FRAME_BITS(3)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .pix_en(pe2), .x(x2), .y(y2), .active(act2),
    .hsync(hs2), .vsync(vs2), .line_start(ls2), .frame_start(fs2), .prefetch_req(pf2),
    .frame_cnt(fc2)
  );

  assign ob[0] = {pe0, 16'(x0), 16'(y0), act0, hs0, vs0, ls0, fs0, pf0, 8'(fc0)};
  assign ob[1] = {pe1, 16'(x1), 16'(y1), act1, hs1, vs1, ls1, fs1, pf1, 8'(fc1)};
  assign ob[2] = {pe2, 16'(x2), 16'(y2), act2, hs2, vs2, ls2, fs2, pf2, 8'(fc2)};

  // n = enabled edges since park, base = frame count held while parked
  function automatic obs_t model(cfg_t c, int n, int base);
    obs_t o;
    int ht, vt, t, xx, yy;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    o = '0;
    if (n < c.dv) begin
      o.x = 16'(ht - 1);
      o.y = 16'(vt - 1);
      o.hs = !c.pol[0];
      o.vs = !c.pol[0];
      o.fc = 8'(base);
      return o;
    end
    t = n / c.dv - 1;
    xx = t % ht;
    yy = (t / ht) % vt;
    o.pe = (n % c.dv) == 0;
    o.x = 16'(xx);
    o.y = 16'(yy);
    o.act = xx < c.ha && yy < c.va;
    o.hs = (xx >= c.ha + c.hfp && xx < c.ha + c.hfp + c.hsw) ? c.pol[0] : !c.pol[0];
    o.vs = (yy >= c.va + c.vfp && yy < c.va + c.vfp + c.vsw) ? c.pol[0] : !c.pol[0];
    o.ls = o.pe && xx == 0;
    o.fs = o.ls && yy == 0;
    o.pf = o.ls && yy == c.pf;
    o.fc = 8'((base + t / (ht * vt) + 1) % (1 << c.fb));
    return o;
  endfunction

  function automatic obs_t mk(bit pe, int xx, int yy, bit a, bit h, bit v, bit l, bit f, bit p, int fc);
    mk = {pe, 16'(xx), 16'(yy), a, h, v, l, f, p, 8'(fc)};
  endfunction

  task automatic chk(string nm, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_obs(string nm, obs_t g, obs_t e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s @%0t: got pe=%0b x=%0d y=%0d a=%0b hs=%0b vs=%0b ls=%0b fs=%0b pf=%0b fc=%0d; expected pe=%0b x=%0d y=%0d a=%0b hs=%0b vs=%0b ls=%0b fs=%0b pf=%0b fc=%0d",
               nm, $time, g.pe, g.x, g.y, g.act, g.hs, g.vs, g.ls, g.fs, g.pf, g.fc,
               e.pe, e.x, e.y, e.act, e.hs, e.vs, e.ls, e.fs, e.pf, e.fc);
    end
  endtask

  int n[3], base[3], fcp[3];
  obs_t ex;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        n[i] = 0;
        base[i] = 0;
        fcp[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!en[i]) begin
          base[i] = fcp[i];
          n[i] = 0;
        end else n[i]++;
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        ex = model(cfg[i], n[i], base[i]);
        chk_obs($sformatf("model[%0d]", i), ob[i], ex);
        fcp[i] = int'(ex.fc);
      end
    end
  end

  vec_t tbl[7];
  int saved;
  bit found;

  initial begin
    tbl[0] = '{1'b0, mk(0, 13, 6, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1] = '{1'b1, mk(1, 0, 0, 1, 0, 0, 1, 1, 1, 1)};
    tbl[2] = '{1'b1, mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 1)};
    tbl[3] = '{1'b0, mk(0, 13, 6, 0, 0, 0, 0, 0, 0, 1)};
    tbl[4] = '{1'b0, mk(0, 13, 6, 0, 0, 0, 0, 0, 0, 1)};
    tbl[5] = '{1'b1, mk(1, 0, 0, 1, 0, 0, 1, 1, 1, 2)};
    tbl[6] = '{1'b1, mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 2)};
    repeat (3) @(negedge clk);
    chk_obs("reset def", ob[0], mk(0, 799, 524, 0, 1, 1, 0, 0, 0, 0));
    chk_obs("reset mid", ob[1], mk(0, 31, 18, 0, 1, 1, 0, 0, 0, 0));
    chk_obs("reset small", ob[2], mk(0, 13, 6, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    for (int r = 0; r < 7; r++) begin
      @(negedge clk);
      en[2] = tbl[r].en;
      @(posedge clk);
      #2;
      chk_obs($sformatf("table row %0d", r), ob[2], tbl[r].e);
    end
    for (int xi = 2; xi < 14; xi++) begin
      @(posedge clk);
      #2;
      chk($sformatf("small hsync x=%0d", xi), int'(ob[2].hs), int'(xi >= 10 && xi < 12));
      chk("small pix_en", int'(ob[2].pe), 1);
    end
    @(negedge clk);
    en[0] = 1'b1;
    en[1] = 1'b1;
    @(posedge clk);
    #2;
    chk("def first edge pix_en", int'(ob[0].pe), 0);
    @(posedge clk);
    #2;
    chk_obs("def first tick", ob[0], mk(1, 0, 0, 1, 1, 1, 1, 1, 0, 1));
    repeat (6500) @(posedge clk);
    found = 0;
    for (int k = 0; k < 2500 && !found; k++) begin
      @(posedge clk);
      #2;
      if (ob[1].x == 20 && ob[1].y == 10) found = 1;
    end
    chk("mid reach (20,10)", int'(found), 1);
    saved = int'(ob[1].fc);
    @(negedge clk);
    en[1] = 1'b0;
    @(posedge clk);
    #2;
    chk_obs("mid disable park", ob[1], mk(0, 31, 18, 0, 1, 1, 0, 0, 0, saved));
    @(negedge clk);
    en[1] = 1'b1;
    @(posedge clk);
    #2;
    chk_obs("mid re-enable edge1", ob[1], mk(0, 31, 18, 0, 1, 1, 0, 0, 0, saved));
    @(posedge clk);
    #2;
    chk_obs("mid re-enable edge2", ob[1], mk(1, 0, 0, 1, 1, 1, 1, 1, 0, (saved + 1) % 4));
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (en[i] ? $urandom_range(0, 99) < 2 : $urandom_range(0, 99) < 20) en[i] = !en[i];
    end
    @(negedge clk);
    en = 3'b111;
    repeat (150) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_obs("async reset def", ob[0], mk(0, 799, 524, 0, 1, 1, 0, 0, 0, 0));
    chk_obs("async reset mid", ob[1], mk(0, 31, 18, 0, 1, 1, 0, 0, 0, 0));
    chk_obs("async reset small", ob[2], mk(0, 13, 6, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
